shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter sharing one DATA_W-bit register (a bank of async-reset D flip-flops) among N_REQ write requesters.
- Grants one requester at a time. A locked requester may hold ownership for up to MAX_HOLD consecutive writes.
- Sits between requesting control blocks and shared status/config storage. Provides the registered value plus a per-write strobe and owner ID.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 8, width of shared register and each write-data lane
- MAX_HOLD, 4, max consecutive owned cycles per grant (>=1)

Ports:
- clk  input  1  clock, rising edge
- async_reset  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester request, level, held until served
- lock  input  N_REQ  per-requester burst request: keep ownership while req stays high
- wdata  input  N_REQ*DATA_W  write data; lane i = bits [i*DATA_W +: DATA_W]
- gnt  output  N_REQ  one-hot grant, registered, all zero when idle
- busy  output  1  registered; 1 while any requester owns the register
- q  output  DATA_W  shared register contents
- q_valid  output  1  registered one-cycle strobe: q updated on the last edge
- q_owner  output  clog2(N_REQ) (min 1)  index of the requester that last wrote q

Behaviour:
- Reset is asynchronous; clock is clk. On async_reset=1, immediately and with no clock edge:
  - gnt=0, busy=0, q=0, q_valid=0, q_owner=0
  - internal owner_vld=0, owner_id=0, ptr=0, hold_cnt=0
  - Reset asserted mid-ownership aborts the grant; no write at that edge.
- States:
  - IDLE: owner_vld=0.
  - OWN: owner_vld=1, owner owner_id. gnt = onehot(owner_id) when OWN, else 0. busy = owner_vld.
- Write rule, in OWN at each edge where req[owner_id]=1:
  - q <= wdata lane owner_id, q_owner <= owner_id, q_valid <= 1.
  - Otherwise q_valid <= 0 and q holds.
- Release condition, evaluated in OWN: !req[owner_id], or !lock[owner_id], or hold_cnt==MAX_HOLD-1.
- On release:
  - ptr <= (owner_id+1) mod N_REQ.
  - Arbitration runs at the same edge, so handover has zero bubble.
- Arbitration, in IDLE or on release:
  - Pick the first i with req[i]=1, scanning ptr, ptr+1, ... wrapping mod N_REQ.
  - The updated ptr is used, so the releasing owner has lowest priority.
  - If found: OWN with owner_id=i, hold_cnt=0. If none: IDLE.
- No release in OWN: hold_cnt <= hold_cnt+1.
- Latency: req sampled at edge k -> gnt high during cycle k+1 -> first write at edge k+2 (q_valid high cycle k+2).
- Requester protocol:
  - Keep wdata stable while gnt[i]=1.
  - Drop req the cycle after the last desired write. A req still high after release is treated as a new request.
- lock=0 gives exactly one write per grant. lock=1 gives up to MAX_HOLD writes.
- req deasserted during own grant: release, no write that edge.
- Single active requester with lock=1 and req held: released after MAX_HOLD writes, then immediately regranted (ptr wraps to it). Continuous writes, hold_cnt reset.
- N_REQ not a power of two: ptr and owner_id wrap at N_REQ; unused codes never produced.

Optional Feature:
- Macro FIXED_PRIO_EN.
- Defined: arbitration ignores ptr and picks the lowest-index asserted req. Release/hold rules are unchanged, so MAX_HOLD still bounds ownership. ptr register is omitted.
- Undefined: round-robin as above.

Test Plan:
- Defaults N_REQ=4, DATA_W=8, MAX_HOLD=4.
- Async reset: from OWN with q=0x3C, pulse async_reset between edges -> gnt=0, busy=0, q=0x00, q_valid=0 immediately. After release, req[3] alone -> gnt=4'b1000 next cycle (ptr=0 scan).
- Single write: req[2]=1, lock[2]=0, lane2=0xA5 at edge 0; req dropped after edge 2 -> gnt=4'b0100 in cycle 1, q=0xA5, q_valid=1, q_owner=2 after edge 2, gnt=0 and busy=0 in cycle 2.
- Rotation: req=4'b1111, lock=0, lanes 0x10,0x11,0x12,0x13 held -> gnt 0001,0010,0100,1000,0001 on consecutive cycles. q sequence 0x10,0x11,0x12,0x13 with q_valid continuously 1, no bubble.
- Hold limit: req=4'b0110, lock[1]=1 from idle -> owner 1 for 4 cycles, 4 writes of lane1, then gnt=4'b0100 next cycle.
- Early drop: owner 1 with lock=1 drops req after 2 writes, req[3]=1 -> no write at the drop edge (q_valid=0), gnt=4'b1000 the following cycle.
- FIXED_PRIO_EN build: req=4'b1001 held, lock=0 -> gnt=0001 every grant; requester 3 never granted while req[0]=1.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the write requesters and the shared register arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface shared_reg_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned OwnerW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        lock;
   logic [N_REQ*DATA_W-1:0] wdata;
   logic [N_REQ-1:0]        gnt;
   logic                    busy;
   logic [DATA_W-1:0]       q;
   logic                    q_valid;
   logic [OwnerW-1:0]       q_owner;

   modport slave (
      input  req, lock, wdata,
      output gnt, busy, q, q_valid, q_owner
   );

   modport master (
      output req, lock, wdata,
      input  gnt, busy, q, q_valid, q_owner
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared DATA_W register, with burst lock up to MAX_HOLD writes.
// Define FIXED_PRIO_EN for lowest-index-wins arbitration (no rotation pointer).
module shared_reg_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input logic                 clk,
   input logic                 async_reset,
   shared_reg_arbiter_if.slave bus
);
   localparam int unsigned OwnerW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned HoldW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e              r_state, w_state_d;
   logic [OwnerW-1:0]   r_owner_id, w_owner_id_d;
   logic [HoldW-1:0]    r_hold_cnt, w_hold_cnt_d;
   logic [N_REQ-1:0]    r_gnt, w_gnt_d;
   logic [DATA_W-1:0]   r_q, w_q_d;
   logic                r_q_valid, w_q_valid_d;
   logic [OwnerW-1:0]   r_q_owner, w_q_owner_d;
   logic                w_own, w_cur_req, w_cur_lock, w_release, w_found;
   logic [OwnerW-1:0]   w_pick;

   assign w_own      = (r_state == StOwn);
   assign w_cur_req  = bus.req[r_owner_id];
   assign w_cur_lock = bus.lock[r_owner_id];
   assign w_release  = w_own && (!w_cur_req || !w_cur_lock || (r_hold_cnt == HoldLast));

`ifdef FIXED_PRIO_EN
   // Descending scan so the lowest asserted index is the last one written.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req[OwnerW'(i)]) begin
            w_found = 1'b1;
            w_pick  = OwnerW'(i);
         end
      end
   end
`else
   logic [OwnerW-1:0] r_ptr, w_ptr_d, w_next_id, w_base;
   logic [OwnerW:0]   w_idx;

   assign w_next_id = (r_owner_id == OwnerW'(N_REQ - 1)) ? '0 : r_owner_id + 1'b1;
   assign w_ptr_d   = w_release ? w_next_id : r_ptr;
   // On release the scan starts past the old owner, giving it lowest priority.
   assign w_base    = w_ptr_d;

   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = {1'b0, w_base} + (OwnerW+1)'(k);
         if (w_idx >= (OwnerW+1)'(N_REQ)) w_idx = w_idx - (OwnerW+1)'(N_REQ);
         if (!w_found && bus.req[w_idx[OwnerW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[OwnerW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) r_ptr <= '0;
      else             r_ptr <= w_ptr_d;
   end
`endif

   always_comb begin
      w_state_d    = r_state;
      w_owner_id_d = r_owner_id;
      w_hold_cnt_d = r_hold_cnt;
      w_gnt_d      = r_gnt;
      w_q_d        = r_q;
      w_q_valid_d  = 1'b0;
      w_q_owner_d  = r_q_owner;

      if (w_own && w_cur_req) begin
         w_q_d       = bus.wdata[r_owner_id * DATA_W +: DATA_W];
         w_q_owner_d = r_owner_id;
         w_q_valid_d = 1'b1;
      end

      if (!w_own || w_release) begin
         w_hold_cnt_d = '0;
         if (w_found) begin
            w_state_d    = StOwn;
            w_owner_id_d = w_pick;
            w_gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
         end else begin
            w_state_d = StIdle;
            w_gnt_d   = '0;
         end
      end else begin
         w_hold_cnt_d = r_hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         r_state    <= StIdle;
         r_owner_id <= '0;
         r_hold_cnt <= '0;
         r_gnt      <= '0;
         r_q        <= '0;
         r_q_valid  <= 1'b0;
         r_q_owner  <= '0;
      end else begin
         r_state    <= w_state_d;
         r_owner_id <= w_owner_id_d;
         r_hold_cnt <= w_hold_cnt_d;
         r_gnt      <= w_gnt_d;
         r_q        <= w_q_d;
         r_q_valid  <= w_q_valid_d;
         r_q_owner  <= w_q_owner_d;
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.busy    = w_own;
   assign bus.q       = r_q;
   assign bus.q_valid = r_q_valid;
   assign bus.q_owner = r_q_owner;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (N_REQ=4, DATA_W=8, MAX_HOLD=4).
// Expected outputs are queued with each step and checked 1 time unit after the clock edge.
module tb_shared_reg_arbiter;
   logic clk = 1'b0;
   logic async_reset = 1'b0;

   shared_reg_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus_if ();

   shared_reg_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
      .clk         (clk),
      .async_reset (async_reset),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] gnt;
      logic       busy;
      logic [7:0] q;
      logic       q_valid;
      logic [1:0] q_owner;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    vectors     = 0;
   int    miscompares = 0;

   task automatic expect_next(input string tag, input logic [3:0] g, input logic b,
                              input logic [7:0] qv, input logic v, input logic [1:0] o);
      obs_t e;
      e = '{gnt: g, busy: b, q: qv, q_valid: v, q_owner: o};
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_all();
      while (exp_q.size() > 0) begin
         obs_t  e;
         obs_t  o;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         o = '{gnt: bus_if.gnt, busy: bus_if.busy, q: bus_if.q, q_valid: bus_if.q_valid,
               q_owner: bus_if.q_owner};
         vectors++;
         assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed gnt=%b busy=%b q=%h q_valid=%b q_owner=%0d, expected gnt=%b busy=%b q=%h q_valid=%b q_owner=%0d",
                   t, o.gnt, o.busy, o.q, o.q_valid, o.q_owner,
                   e.gnt, e.busy, e.q, e.q_valid, e.q_owner);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] l);
      bus_if.req  = r;
      bus_if.lock = l;
   endtask

   task automatic do_reset(input string tag);
      async_reset = 1'b1;
      #1;
      expect_next(tag, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      check_all();
      drive(4'b0000, 4'b0000);
      async_reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, required $finish");
      $fatal(1);
   end

   initial begin
      bus_if.req   = '0;
      bus_if.lock  = '0;
      bus_if.wdata = '0;
      #2;
      do_reset("reset_initial");

      // Single write, lock=0: write at second edge, requester still high is regranted.
      bus_if.wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
      drive(4'b0100, 4'b0000);
      expect_next("single_gnt", 4'b0100, 1'b1, 8'h00, 1'b0, 2'd0); tick();
      expect_next("single_wr",  4'b0100, 1'b1, 8'hA5, 1'b1, 2'd2); tick();
      drive(4'b0000, 4'b0000);
      expect_next("single_drop", 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd2); tick();

      // Async reset mid-ownership with q=0x3C.
      do_reset("reset_pre_own");
      bus_if.wdata = {8'h77, 8'h00, 8'h00, 8'h3C};
      drive(4'b0001, 4'b0001);
      expect_next("own0_gnt", 4'b0001, 1'b1, 8'h00, 1'b0, 2'd0); tick();
      expect_next("own0_wr",  4'b0001, 1'b1, 8'h3C, 1'b1, 2'd0); tick();
      #2;
      do_reset("reset_mid_own");
      drive(4'b1000, 4'b0000);
      expect_next("post_rst_gnt3", 4'b1000, 1'b1, 8'h00, 1'b0, 2'd0); tick();
      expect_next("post_rst_wr3",  4'b1000, 1'b1, 8'h77, 1'b1, 2'd3); tick();
      drive(4'b0000, 4'b0000);
      expect_next("post_rst_idle", 4'b0000, 1'b0, 8'h77, 1'b0, 2'd3); tick();

      // Rotation across all four with no bubble.
      do_reset("reset_rot");
      bus_if.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
      drive(4'b1111, 4'b0000);
      expect_next("rot_g0", 4'b0001, 1'b1, 8'h00, 1'b0, 2'd0); tick();
      expect_next("rot_g1", 4'b0010, 1'b1, 8'h10, 1'b1, 2'd0); tick();
      expect_next("rot_g2", 4'b0100, 1'b1, 8'h11, 1'b1, 2'd1); tick();
      expect_next("rot_g3", 4'b1000, 1'b1, 8'h12, 1'b1, 2'd2); tick();
      expect_next("rot_g0b", 4'b0001, 1'b1, 8'h13, 1'b1, 2'd3); tick();
      drive(4'b0000, 4'b0000);
      expect_next("rot_idle", 4'b0000, 1'b0, 8'h13, 1'b0, 2'd3); tick();

      // Hold limit: locked owner 1 gets exactly four writes, then hands to 2.
      do_reset("reset_hold");
      bus_if.wdata = {8'h00, 8'h22, 8'h21, 8'h00};
      drive(4'b0110, 4'b0010);
      expect_next("hold_gnt", 4'b0010, 1'b1, 8'h00, 1'b0, 2'd0); tick();
      expect_next("hold_w1",  4'b0010, 1'b1, 8'h21, 1'b1, 2'd1); tick();
      expect_next("hold_w2",  4'b0010, 1'b1, 8'h21, 1'b1, 2'd1); tick();
      expect_next("hold_w3",  4'b0010, 1'b1, 8'h21, 1'b1, 2'd1); tick();
      expect_next("hold_w4",  4'b0100, 1'b1, 8'h21, 1'b1, 2'd1); tick();
      drive(4'b0100, 4'b0000);
      expect_next("hold_next", 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2); tick();
      drive(4'b0000, 4'b0000);
      expect_next("hold_idle", 4'b0000, 1'b0, 8'h22, 1'b0, 2'd2); tick();

      // Early drop: no write at the drop edge, requester 3 takes over.
      do_reset("reset_drop");
      bus_if.wdata = {8'h33, 8'h00, 8'h31, 8'h00};
      drive(4'b0010, 4'b0010);
      expect_next("drop_gnt", 4'b0010, 1'b1, 8'h00, 1'b0, 2'd0); tick();
      expect_next("drop_w1",  4'b0010, 1'b1, 8'h31, 1'b1, 2'd1); tick();
      expect_next("drop_w2",  4'b0010, 1'b1, 8'h31, 1'b1, 2'd1); tick();
      drive(4'b1000, 4'b0000);
      expect_next("drop_edge", 4'b1000, 1'b1, 8'h31, 1'b0, 2'd1); tick();
      expect_next("drop_wr3",  4'b1000, 1'b1, 8'h33, 1'b1, 2'd3); tick();
      drive(4'b0000, 4'b0000);
      expect_next("drop_idle", 4'b0000, 1'b0, 8'h33, 1'b0, 2'd3); tick();

      // Requesters 0 and 3 contending.
      do_reset("reset_pair");
      bus_if.wdata = {8'h43, 8'h00, 8'h00, 8'h40};
      drive(4'b1001, 4'b0000);
      expect_next("pair_gnt", 4'b0001, 1'b1, 8'h00, 1'b0, 2'd0); tick();
`ifdef FIXED_PRIO_EN
      expect_next("fixed_w1", 4'b0001, 1'b1, 8'h40, 1'b1, 2'd0); tick();
      expect_next("fixed_w2", 4'b0001, 1'b1, 8'h40, 1'b1, 2'd0); tick();
      expect_next("fixed_w3", 4'b0001, 1'b1, 8'h40, 1'b1, 2'd0); tick();
`else
      expect_next("rr_w1", 4'b1000, 1'b1, 8'h40, 1'b1, 2'd0); tick();
      expect_next("rr_w2", 4'b0001, 1'b1, 8'h43, 1'b1, 2'd3); tick();
      expect_next("rr_w3", 4'b1000, 1'b1, 8'h40, 1'b1, 2'd0); tick();
`endif
      drive(4'b0000, 4'b0000);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
